// File: rtl/unlock_guard.sv
`default_nettype none
// ============================================================================
// Module   : unlock_guard
// Purpose  : Guarded access sequencer behind the combinational key checker.
//            An accepted attempt is judged one cycle later; a good key opens
//            a timed access window, bad keys are counted and enough
//            consecutive failures trigger a timed lockout.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk            in   clock, rising edge
//   rst            in   synchronous active-high reset
//   attempt_valid  in   attempt offered this cycle
//   attempt_ready  out  guard can accept an attempt (IDLE only)
//   unlock         in   key-check result from the upstream checker
//   kind [1:0]     in   attempt kind code (checker encoding)
//   relock         in   early close of the open window
//   door_open      out  access window active
//   locked_out     out  lockout active
//   grant_pulse    out  one-cycle grant strobe
//   deny_pulse     out  one-cycle deny strobe
//   fail_count     out  consecutive-failure count, saturates at MAX_FAILS
// Optional macro:
//   UNLOCK_GUARD_ASSERT_EN - embeds invariant assertions and an input
//   stability assumption; functional logic is identical either way.
// ============================================================================
module unlock_guard #(
    parameter int           MAX_FAILS      = 3,
    parameter int           OPEN_CYCLES    = 8,
    parameter int           LOCKOUT_CYCLES = 16,
    parameter logic [1:0]   KIND_OK        = 2'b10
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               attempt_valid,
    output logic                               attempt_ready,
    input  logic                               unlock,
    input  logic [1:0]                         kind,
    input  logic                               relock,
    output logic                               door_open,
    output logic                               locked_out,
    output logic                               grant_pulse,
    output logic                               deny_pulse,
    output logic [$clog2(MAX_FAILS+1)-1:0]     fail_count
);

    localparam int FCW  = $clog2(MAX_FAILS + 1);
    localparam int TMAX = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [1:0] c_idle    = 2'd0;
    localparam logic [1:0] c_check   = 2'd1;
    localparam logic [1:0] c_open    = 2'd2;
    localparam logic [1:0] c_lockout = 2'd3;

    localparam logic [FCW-1:0] c_max_fails = FCW'(MAX_FAILS);
    localparam logic [FCW-1:0] c_fail_one  = FCW'(1);
    localparam logic [TW-1:0]  c_open_load = TW'(OPEN_CYCLES - 1);
    localparam logic [TW-1:0]  c_lock_load = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [TW-1:0]  c_timer_one = TW'(1);

    logic [1:0]     state_q,      state_d;
    logic           unlock_q,     unlock_d;
    logic [1:0]     kind_q,       kind_d;
    logic [FCW-1:0] fail_count_q, fail_count_d;
    logic [TW-1:0]  timer_q,      timer_d;
    logic           grant_q,      grant_d;
    logic           deny_q,       deny_d;

    logic           w_accept;
    logic           w_success;
    logic [FCW-1:0] w_fail_inc;
    logic [TW-1:0]  w_timer_dec;

    assign w_accept    = attempt_valid && attempt_ready;
    assign w_success   = unlock_q && (kind_q == KIND_OK);
    assign w_fail_inc  = (fail_count_q >= c_max_fails) ? c_max_fails
                                                       : fail_count_q + c_fail_one;
    // Timer floors at zero so a stray extra cycle can never wrap it.
    assign w_timer_dec = (timer_q == '0) ? '0 : timer_q - c_timer_one;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= c_idle;
            unlock_q     <= 1'b0;
            kind_q       <= 2'b00;
            fail_count_q <= '0;
            timer_q      <= '0;
            grant_q      <= 1'b0;
            deny_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            unlock_q     <= unlock_d;
            kind_q       <= kind_d;
            fail_count_q <= fail_count_d;
            timer_q      <= timer_d;
            grant_q      <= grant_d;
            deny_q       <= deny_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        unlock_d     = unlock_q;
        kind_d       = kind_q;
        fail_count_d = fail_count_q;
        timer_d      = timer_q;
        grant_d      = 1'b0;
        deny_d       = 1'b0;

        case (state_q)
            c_idle: begin
                // The attempt is captured only here, so the checker inputs
                // are free to change once the guard leaves IDLE.
                if (w_accept) begin
                    unlock_d = unlock;
                    kind_d   = kind;
                    state_d  = c_check;
                end
            end

            c_check: begin
                if (w_success) begin
                    grant_d      = 1'b1;
                    fail_count_d = '0;
                    timer_d      = c_open_load;
                    state_d      = c_open;
                end else begin
                    deny_d       = 1'b1;
                    fail_count_d = w_fail_inc;
                    if (w_fail_inc == c_max_fails) begin
                        timer_d = c_lock_load;
                        state_d = c_lockout;
                    end else begin
                        state_d = c_idle;
                    end
                end
            end

            c_open: begin
                // relock wins over natural expiry.
                if (relock || (timer_q == '0)) begin
                    state_d = c_idle;
                end else begin
                    timer_d = w_timer_dec;
                end
            end

            c_lockout: begin
                if (timer_q == '0) begin
                    fail_count_d = '0;
                    state_d      = c_idle;
                end else begin
                    timer_d = w_timer_dec;
                end
            end

            default: state_d = c_idle;
        endcase
    end

    // ------------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------------
    always_comb begin
        attempt_ready = 1'b0;
        door_open     = 1'b0;
        locked_out    = 1'b0;
        // Ready is masked by rst so nothing is offered during reset even in
        // the cycle before the state register is cleared.
        attempt_ready = (state_q == c_idle) && !rst;
        door_open     = (state_q == c_open);
        locked_out    = (state_q == c_lockout);
    end

    assign grant_pulse = grant_q;
    assign deny_pulse  = deny_q;
    assign fail_count  = fail_count_q;

`ifdef UNLOCK_GUARD_ASSERT_EN
    a_open_lock_excl: assert property (@(posedge clk) disable iff (rst)
        !(door_open && locked_out));
    a_fail_bound: assert property (@(posedge clk) disable iff (rst)
        fail_count <= c_max_fails);
    a_pulse_excl: assert property (@(posedge clk) disable iff (rst)
        !(grant_pulse && deny_pulse));
    a_door_state: assert property (@(posedge clk) disable iff (rst)
        door_open |-> (state_q == c_open));
    a_grant_door: assert property (@(posedge clk) disable iff (rst)
        grant_pulse |-> door_open);
    m_input_stable: assume property (@(posedge clk) disable iff (rst)
        (attempt_valid && !attempt_ready) |=> ($stable(kind) && $stable(unlock)));
`endif

endmodule
`default_nettype wire

// File: tb/tb_unlock_guard.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_unlock_guard
// Purpose  : Self-checking bench for unlock_guard. A rule-level model tracks
//            the consecutive-failure count and the expected window lengths
//            for each attempt outcome.
// Revision : 1.0 - initial release
// ============================================================================
module tb_unlock_guard;

    localparam int         MAX_FAILS      = 3;
    localparam int         OPEN_CYCLES    = 8;
    localparam int         LOCKOUT_CYCLES = 16;
    localparam logic [1:0] KIND_OK        = 2'b10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       attempt_valid = 1'b0;
    logic       unlock = 1'b0;
    logic [1:0] kind = 2'b00;
    logic       relock = 1'b0;
    logic       attempt_ready;
    logic       door_open;
    logic       locked_out;
    logic       grant_pulse;
    logic       deny_pulse;
    logic [1:0] fail_count;

    int errors = 0;
    int checks = 0;
    int m_fails = 0;   // model: consecutive failures

    always #5 clk = ~clk;

    unlock_guard #(
        .MAX_FAILS      (MAX_FAILS),
        .OPEN_CYCLES    (OPEN_CYCLES),
        .LOCKOUT_CYCLES (LOCKOUT_CYCLES),
        .KIND_OK        (KIND_OK)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .attempt_valid (attempt_valid),
        .attempt_ready (attempt_ready),
        .unlock        (unlock),
        .kind          (kind),
        .relock        (relock),
        .door_open     (door_open),
        .locked_out    (locked_out),
        .grant_pulse   (grant_pulse),
        .deny_pulse    (deny_pulse),
        .fail_count    (fail_count)
    );

    // Offer one attempt; returns on the verdict cycle (negedge).
    task automatic attempt(input bit u, input logic [1:0] k, input bit noise);
        int w = 0;
        while (!attempt_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (attempt_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_timeout: attempt_ready=%b required 1", attempt_ready);
        end
        attempt_valid = 1'b1; unlock = u; kind = k; relock = noise;
        @(negedge clk);
        // Garbage during CHECK must not be sampled.
        attempt_valid = 1'b0; unlock = 1'($urandom); kind = 2'($urandom); relock = noise;
        @(negedge clk);
        relock = 1'b0;
    endtask

    // Count cycles of an active window, optionally pulsing relock on cycle relock_at.
    task automatic run_window(input int relock_at, output int n, output int pulses);
        n = 0; pulses = 0;
        while ((door_open || locked_out) && n < 200) begin
            n++;
            if (grant_pulse || deny_pulse) pulses++;
            relock = (n == relock_at);
            @(negedge clk);
        end
        relock = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({door_open, locked_out, grant_pulse, deny_pulse, attempt_ready} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 00000", {door_open, locked_out, grant_pulse, deny_pulse, attempt_ready});
        end
        checks++;
        if (fail_count !== 2'd0) begin
            errors++;
            $display("FAIL reset_fail_count: got %0d required 0", fail_count);
        end
        @(negedge clk);
        checks++;
        if (attempt_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_held: got %b required 0", attempt_ready);
        end
        rst = 1'b0;
        m_fails = 0;
        @(negedge clk);
        checks++;
        if (attempt_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b required 1", attempt_ready);
        end
    endtask

    task automatic test_grant();
        int n, p;
        attempt(1'b1, KIND_OK, 1'b0);
        m_fails = 0;
        checks++;
        if ({grant_pulse, deny_pulse} !== 2'b10) begin
            errors++;
            $display("FAIL grant_pulse: grant/deny=%b required 10", {grant_pulse, deny_pulse});
        end
        checks++;
        if (fail_count !== 2'(m_fails)) begin
            errors++;
            $display("FAIL grant_fail_count: got %0d required %0d", fail_count, m_fails);
        end
        run_window(0, n, p);
        checks++;
        if (n != OPEN_CYCLES || p != 1) begin
            errors++;
            $display("FAIL grant_window: open=%0d pulses=%0d required %0d and 1", n, p, OPEN_CYCLES);
        end
        checks++;
        if (attempt_ready !== 1'b1) begin
            errors++;
            $display("FAIL grant_return_idle: ready=%b required 1", attempt_ready);
        end
    endtask

    task automatic test_lockout();
        int n, p;
        logic [1:0] k;
        bit u;
        for (int i = 1; i <= MAX_FAILS; i++) begin
            k = (i % 2 == 1) ? 2'b11 : KIND_OK;
            u = (k == KIND_OK) ? 1'b0 : 1'($urandom);
            attempt(u, k, 1'($urandom));
            m_fails = (m_fails + 1 > MAX_FAILS) ? MAX_FAILS : m_fails + 1;
            checks++;
            if ({grant_pulse, deny_pulse} !== 2'b01 || fail_count !== 2'(m_fails)) begin
                errors++;
                $display("FAIL lockout_deny_%0d: grant/deny=%b count=%0d required 01 and %0d", i, {grant_pulse, deny_pulse}, fail_count, m_fails);
            end
            checks++;
            if ({locked_out, attempt_ready} !== ((m_fails == MAX_FAILS) ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL lockout_state_%0d: locked/ready=%b after %0d fails", i, {locked_out, attempt_ready}, m_fails);
            end
        end
        run_window(3, n, p);   // relock during lockout is ignored
        m_fails = 0;
        checks++;
        if (n != LOCKOUT_CYCLES || p != 1) begin
            errors++;
            $display("FAIL lockout_window: locked=%0d pulses=%0d required %0d and 1", n, p, LOCKOUT_CYCLES);
        end
        checks++;
        if (fail_count !== 2'd0 || attempt_ready !== 1'b1) begin
            errors++;
            $display("FAIL lockout_exit: count=%0d ready=%b required 0 and 1", fail_count, attempt_ready);
        end
    endtask

    task automatic test_relock();
        int n, p;
        attempt(1'b1, KIND_OK, 1'b0);
        m_fails = 0;
        run_window(3, n, p);
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL relock_window: open=%0d required 3", n);
        end
        checks++;
        if (door_open !== 1'b0 || attempt_ready !== 1'b1) begin
            errors++;
            $display("FAIL relock_idle: door=%b ready=%b required 0 and 1", door_open, attempt_ready);
        end
    endtask

    task automatic test_recover();
        int n, p;
        for (int i = 0; i < 2; i++) begin
            attempt(1'b1, 2'b01, 1'b0);
            m_fails++;
            checks++;
            if (fail_count !== 2'(m_fails)) begin
                errors++;
                $display("FAIL recover_count_%0d: got %0d required %0d", i, fail_count, m_fails);
            end
        end
        attempt(1'b1, KIND_OK, 1'b0);
        m_fails = 0;
        checks++;
        if (fail_count !== 2'd0 || grant_pulse !== 1'b1 || locked_out !== 1'b0) begin
            errors++;
            $display("FAIL recover_grant: count=%0d grant=%b locked=%b required 0,1,0", fail_count, grant_pulse, locked_out);
        end
        run_window(0, n, p);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < MAX_FAILS; i++) attempt(1'b0, 2'b00, 1'b0);
        repeat (4) @(negedge clk);   // now in the 5th lockout cycle
        checks++;
        if (locked_out !== 1'b1) begin
            errors++;
            $display("FAIL midreset_pre: locked=%b required 1", locked_out);
        end
        rst = 1'b1;
        @(negedge clk);
        m_fails = 0;
        checks++;
        if ({door_open, locked_out, grant_pulse, deny_pulse, attempt_ready} !== 5'b0 || fail_count !== 2'd0) begin
            errors++;
            $display("FAIL midreset_outputs: outs=%b count=%0d required 00000 and 0", {door_open, locked_out, grant_pulse, deny_pulse, attempt_ready}, fail_count);
        end
        rst = 1'b0;
        // Reset while a verdict is pending: no pulse, no window.
        @(negedge clk);
        attempt_valid = 1'b1; unlock = 1'b1; kind = KIND_OK;
        @(negedge clk);
        attempt_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({grant_pulse, deny_pulse, door_open} !== 3'b000 || attempt_ready !== 1'b1) begin
            errors++;
            $display("FAIL pending_discard: grant/deny/door=%b ready=%b required 000 and 1", {grant_pulse, deny_pulse, door_open}, attempt_ready);
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        attempt(1'b1, KIND_OK, 1'b0);
        m_fails = 0;
        attempt_valid = 1'b1; unlock = 1'b0; kind = 2'b00;   // held while busy
        while (door_open && n < 50) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != OPEN_CYCLES || attempt_ready !== 1'b1) begin
            errors++;
            $display("FAIL held_valid_window: open=%0d ready=%b required %0d and 1", n, attempt_ready, OPEN_CYCLES);
        end
        @(negedge clk);
        attempt_valid = 1'b0;
        checks++;
        if (attempt_ready !== 1'b0) begin
            errors++;
            $display("FAIL held_valid_accept: ready=%b required 0", attempt_ready);
        end
        @(negedge clk);
        m_fails = 1;
        checks++;
        if (deny_pulse !== 1'b1 || fail_count !== 2'(m_fails)) begin
            errors++;
            $display("FAIL held_valid_verdict: deny=%b count=%0d required 1 and %0d", deny_pulse, fail_count, m_fails);
        end
    endtask

    task automatic test_random();
        int n, p, rl, exp_n;
        bit u, succ;
        logic [1:0] k;
        for (int it = 0; it < 40; it++) begin
            u    = 1'($urandom);
            k    = 2'($urandom);
            if (it % 5 == 0) begin u = 1'b1; k = KIND_OK; end
            succ = u && (k == KIND_OK);
            rl   = $urandom_range(0, OPEN_CYCLES + 2);
            attempt(u, k, 1'($urandom));
            m_fails = succ ? 0 : ((m_fails + 1 > MAX_FAILS) ? MAX_FAILS : m_fails + 1);
            checks++;
            if ({grant_pulse, deny_pulse} !== {succ, !succ} || fail_count !== 2'(m_fails)) begin
                errors++;
                $display("FAIL rand_verdict_%0d: grant/deny=%b count=%0d required %b%b and %0d", it, {grant_pulse, deny_pulse}, fail_count, succ, !succ, m_fails);
            end
            if (succ) begin
                exp_n = (rl >= 1 && rl <= OPEN_CYCLES) ? rl : OPEN_CYCLES;
            end else if (m_fails == MAX_FAILS) begin
                exp_n = LOCKOUT_CYCLES;
                m_fails = 0;
            end else begin
                exp_n = 0;
            end
            run_window(rl, n, p);
            checks++;
            if (n != exp_n || fail_count !== 2'(m_fails) || attempt_ready !== 1'b1) begin
                errors++;
                $display("FAIL rand_window_%0d: len=%0d count=%0d ready=%b required %0d, %0d, 1", it, n, fail_count, attempt_ready, exp_n, m_fails);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_grant();
        test_lockout();
        test_relock();
        test_recover();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
